// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
//   Groups the boot loader's byte-stream handshake and instruction-SRAM bus.
//
//   Stream side : in_data, in_valid (source -> loader), in_ready (loader -> source)
//   SRAM side   : mem_addr, mem_wdata, mem_we, mem_re (loader -> SRAM),
//                 mem_rdata (SRAM -> loader, valid the cycle after mem_re)
//
//   modport master : the boot loader (drives the SRAM, consumes the stream)
//   modport slave  : the environment (byte source plus SRAM)
// ---------------------------------------------------------------------------
interface boot_loader_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  in_data, in_valid, mem_rdata,
      output in_ready, mem_addr, mem_wdata, mem_we, mem_re
   );

   modport slave (
      output in_data, in_valid, mem_rdata,
      input  in_ready, mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//   Boot-time initiator on the instruction-memory bus. Receives a byte stream
//   (16-bit little-endian word count N, then 4*N little-endian image bytes),
//   writes the assembled 32-bit words to SRAM words 0..N-1 and holds the core
//   in reset until the image is in place.
//
//   Optional feature: define BOOT_LOADER_VERIFY_EN to add a read-back pass that
//   compares the XOR of all read words with the XOR of all written words
//   before releasing the core; a mismatch ends in ERROR.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : boot_loader_if.master (stream handshake + SRAM bus)
//   core_rst : core reset, high until the load completes
//   done     : image loaded (and verified)
//   error    : load failed (N > 2**ADDR_W or verify mismatch); sticky
// ---------------------------------------------------------------------------
module boot_loader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   boot_loader_if.master bus,
   output logic          core_rst,
   output logic          done,
   output logic          error
);
   localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE = 1;

   typedef enum logic [2:0] {
      S_HDR0, S_HDR1, S_DATA, S_WRITE, S_VERIFY, S_DONE, S_ERROR
   } state_t;

   state_t              state, state_nxt;
   logic [7:0]          n_lo;
   logic [ADDR_W:0]     n_words;     // word count, 1..2**ADDR_W once in DATA
   logic [ADDR_W-1:0]   idx;         // index of the word being assembled
   logic [1:0]          byte_cnt;
   logic [DATA_W-9:0]   word_buf;    // first three bytes of the current word
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                mem_we_q;

   logic                accept;
   logic                last_word;
   logic [15:0]         n_full;
   logic [DATA_W-1:0]   assembled;

`ifdef BOOT_LOADER_VERIFY_EN
   logic [DATA_W-1:0]   cs;          // XOR of all written words
   logic [DATA_W-1:0]   rc;          // XOR of all read-back words so far
   logic [ADDR_W:0]     rd_cnt;      // reads issued so far
   logic                rd_valid;    // mem_rdata carries a read result this cycle
   logic                mem_re_q;
   logic                verify_end;

   // Last read result is on mem_rdata and no further read is in flight.
   assign verify_end = rd_valid & ~mem_re_q;
   assign bus.mem_re = mem_re_q;
`else
   assign bus.mem_re = 1'b0;
`endif

   assign bus.in_ready  = ~rst & (state == S_HDR0 || state == S_HDR1 || state == S_DATA);
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_we    = mem_we_q;

   assign accept    = bus.in_valid & bus.in_ready;
   assign n_full    = {bus.in_data, n_lo};
   assign assembled = {bus.in_data, word_buf};
   assign last_word = ({1'b0, idx} + CNT_ONE) == n_words;

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_HDR0: if (accept) state_nxt = S_HDR1;
         S_HDR1:
            if (accept) begin
               if (n_full == 16'd0)                 state_nxt = S_DONE;
               else if ({1'b0, n_full} > MAX_WORDS) state_nxt = S_ERROR;
               else                                 state_nxt = S_DATA;
            end
         S_DATA: if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
         S_WRITE:
            if (last_word) begin
`ifdef BOOT_LOADER_VERIFY_EN
               state_nxt = S_VERIFY;
`else
               state_nxt = S_DONE;
`endif
            end else begin
               state_nxt = S_DATA;
            end
`ifdef BOOT_LOADER_VERIFY_EN
         S_VERIFY:
            if (verify_end)
               state_nxt = ((rc ^ bus.mem_rdata) == cs) ? S_DONE : S_ERROR;
`endif
         S_DONE, S_ERROR: state_nxt = state;
         default:         state_nxt = S_HDR0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: only this block's registers are reset; the SRAM it loads is
         // external and keeps whatever was written before the reset.
         state       <= S_HDR0;
         n_lo        <= '0;
         n_words     <= '0;
         idx         <= '0;
         byte_cnt    <= '0;
         word_buf    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         core_rst    <= 1'b1;
         done        <= 1'b0;
         error       <= 1'b0;
`ifdef BOOT_LOADER_VERIFY_EN
         cs          <= '0;
         rc          <= '0;
         rd_cnt      <= '0;
         rd_valid    <= 1'b0;
         mem_re_q    <= 1'b0;
`endif
      end else begin
         state <= state_nxt;

         case (state)
            S_HDR0: if (accept) n_lo <= bus.in_data;
            S_HDR1:
               if (accept) begin
                  n_words  <= n_full[ADDR_W:0];
                  idx      <= '0;
                  byte_cnt <= '0;
               end
            S_DATA:
               if (accept) begin
                  word_buf <= assembled[DATA_W-1:8];
                  byte_cnt <= byte_cnt + 2'd1;
               end
            S_WRITE: begin
               // Wraps to 0 after the final word when N is the full depth.
               idx <= idx + IDX_ONE;
`ifdef BOOT_LOADER_VERIFY_EN
               cs  <= cs ^ mem_wdata_q;
`endif
            end
            default: ;
         endcase

         // Registered bus outputs are loaded from the state being entered so
         // they are valid throughout that state's cycle.
         mem_we_q <= (state_nxt == S_WRITE);
         if (state_nxt == S_WRITE) begin
            mem_addr_q  <= idx;
            mem_wdata_q <= assembled;
         end

`ifdef BOOT_LOADER_VERIFY_EN
         mem_re_q <= 1'b0;
         rd_valid <= mem_re_q;
         if (rd_valid) rc <= rc ^ bus.mem_rdata;
         if (state == S_WRITE && last_word) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= '0;
            rd_cnt     <= CNT_ONE;
         end else if (state == S_VERIFY && rd_cnt < n_words) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= rd_cnt[ADDR_W-1:0];
            rd_cnt     <= rd_cnt + CNT_ONE;
         end
`endif

         core_rst <= (state_nxt != S_DONE);
         done     <= (state_nxt == S_DONE);
         error    <= (state_nxt == S_ERROR);
      end
   end
endmodule
